// File: rtl/antares_fetch_unit.sv
// rtl/antares_fetch_unit.sv - instruction fetch stage: one imem read per PC, stall buffering, flush, bus error/timeout
module antares_fetch_unit #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_stall,
    input  logic        if_flush,
    output logic [31:0] imem_address,
    output logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        imem_error,
    output logic [31:0] if_instruction,
    output logic        if_inst_valid,
    output logic        if_bus_error,
    output logic        if_fetch_stall
);

    localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DROP, HOLD} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [31:0]   buf_word;
    logic          buf_err;
    logic          timeout;
    logic          resp_done;
    logic          deliver;
    logic [31:0]   resp_word;
    logic          resp_err;

    assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST) && !imem_ready;
    assign resp_done = imem_ready || timeout;
    // A timeout is reported exactly like an erroring response.
    assign resp_word = (imem_ready && !imem_error) ? imem_data : NOP_WORD;
    assign resp_err  = !imem_ready || imem_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: next_state = if_flush ? IDLE : BUSY;
            BUSY: begin
                if (resp_done) begin
                    if (if_flush)      next_state = IDLE;
                    else if (if_stall) next_state = HOLD;
                    else               next_state = IDLE;
                end else if (if_flush) begin
                    next_state = DROP;
                end
            end
            DROP: if (resp_done) next_state = IDLE;
            HOLD: if (if_flush || !if_stall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        deliver        = 1'b0;
        if_instruction = NOP_WORD;
        if_bus_error   = 1'b0;
        if (!rst) begin
            unique case (state)
                BUSY: begin
                    if (resp_done && !if_flush) begin
                        deliver        = 1'b1;
                        if_instruction = resp_word;
                        if_bus_error   = resp_err;
                    end
                end
                HOLD: begin
                    deliver        = 1'b1;
                    if_instruction = buf_word;
                    if_bus_error   = buf_err;
                end
                default: deliver = 1'b0;
            endcase
        end
    end

    assign if_inst_valid  = deliver;
    assign if_fetch_stall = !deliver;

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_valid   <= 1'b0;
            imem_address <= 32'h0;
            buf_word     <= NOP_WORD;
            buf_err      <= 1'b0;
            cnt          <= '0;
        end else begin
            imem_valid <= (next_state == BUSY) || (next_state == DROP);
            if (state == IDLE && next_state == BUSY) begin
                imem_address <= if_pc;
                cnt          <= '0;
            end else if ((state == BUSY || state == DROP) && !imem_ready && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (state == BUSY && next_state == HOLD) begin
                buf_word <= resp_word;
                buf_err  <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_antares_fetch_unit.sv
// tb/tb_antares_fetch_unit.sv - directed self-checking bench for antares_fetch_unit
module tb_antares_fetch_unit;

    localparam logic [31:0] NOP = 32'hFFFF_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        if_flush;
    logic [31:0] imem_address;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        imem_error;
    logic [31:0] if_instruction;
    logic        if_inst_valid;
    logic        if_bus_error;
    logic        if_fetch_stall;

    int n_checks = 0;
    int n_fail   = 0;

    antares_fetch_unit #(.TIMEOUT_CYCLES(8), .NOP_WORD(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_stall       (if_stall),
        .if_flush       (if_flush),
        .imem_address   (imem_address),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .imem_ready     (imem_ready),
        .imem_error     (imem_error),
        .if_instruction (if_instruction),
        .if_inst_valid  (if_inst_valid),
        .if_bus_error   (if_bus_error),
        .if_fetch_stall (if_fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'hBFC0_0000; if_stall = 1'b0; if_flush = 1'b0;
        imem_data = 32'h0; imem_ready = 1'b0; imem_error = 1'b0;
        repeat (3) tick();
        settle();
        check("rst_imem_valid", 32'(imem_valid), 0);
        check("rst_imem_addr", imem_address, 32'h0);
        check("rst_inst_valid", 32'(if_inst_valid), 0);
        check("rst_fetch_stall", 32'(if_fetch_stall), 1);

        // T1: release reset, first launch
        rst = 1'b0;
        settle();
        check("idle_fetch_stall", 32'(if_fetch_stall), 1);
        tick();
        check("t1_imem_valid", 32'(imem_valid), 1);
        check("t1_imem_addr", imem_address, 32'hBFC0_0000);

        // T2: zero-wait response
        imem_ready = 1'b1; imem_data = 32'h2402_0001;
        settle();
        check("t2_inst_valid", 32'(if_inst_valid), 1);
        check("t2_instr", if_instruction, 32'h2402_0001);
        check("t2_fetch_stall", 32'(if_fetch_stall), 0);
        check("t2_bus_error", 32'(if_bus_error), 0);
        tick();
        imem_ready = 1'b0; if_pc = 32'hBFC0_0004;
        settle();
        check("t2_idle_valid", 32'(imem_valid), 0);
        check("t2_idle_stall", 32'(if_fetch_stall), 1);
        tick();
        check("t2_next_valid", 32'(imem_valid), 1);
        check("t2_next_addr", imem_address, 32'hBFC0_0004);

        // T3: two wait states, then stall for 4 cycles at delivery
        for (int i = 0; i < 2; i++) begin
            settle();
            check("t3_wait_stall", 32'(if_fetch_stall), 1);
            tick();
        end
        imem_ready = 1'b1; imem_data = 32'h1111_2222; if_stall = 1'b1;
        settle();
        check("t3_deliver_valid", 32'(if_inst_valid), 1);
        check("t3_deliver_instr", if_instruction, 32'h1111_2222);
        tick();
        imem_ready = 1'b0; imem_data = 32'h0; if_pc = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_hold_valid", 32'(if_inst_valid), 1);
            check("t3_hold_instr", if_instruction, 32'h1111_2222);
            check("t3_hold_no_req", 32'(imem_valid), 0);
            tick();
        end
        if_stall = 1'b0;
        settle();
        check("t3_release_valid", 32'(if_inst_valid), 1);
        check("t3_release_instr", if_instruction, 32'h1111_2222);
        tick();
        check("t3_idle_valid", 32'(if_inst_valid), 0);
        check("t3_idle_req", 32'(imem_valid), 0);
        tick();
        check("t3_next_addr", imem_address, 32'hBFC0_0008);

        // T4: flush while waiting, late response discarded
        if_flush = 1'b1;
        settle();
        check("t4_flush_valid", 32'(if_inst_valid), 0);
        tick();
        if_flush = 1'b0; if_pc = 32'h8000_0100;
        check("t4_drop_req_alive", 32'(imem_valid), 1);
        check("t4_drop_addr", imem_address, 32'hBFC0_0008);
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
        settle();
        check("t4_drop_resp_valid", 32'(if_inst_valid), 0);
        check("t4_drop_resp_stall", 32'(if_fetch_stall), 1);
        tick();
        imem_ready = 1'b0;
        check("t4_idle_req", 32'(imem_valid), 0);
        check("t4_idle_valid", 32'(if_inst_valid), 0);
        tick();
        check("t4_new_addr", imem_address, 32'h8000_0100);
        check("t4_new_valid", 32'(imem_valid), 1);

        // T5: timeout after 8 BUSY cycles
        for (int i = 0; i < 7; i++) begin
            settle();
            check("t5_wait_valid", 32'(if_inst_valid), 0);
            tick();
        end
        settle();
        check("t5_to_valid", 32'(if_inst_valid), 1);
        check("t5_to_err", 32'(if_bus_error), 1);
        check("t5_to_instr", if_instruction, NOP);
        tick();
        check("t5_to_req_drop", 32'(imem_valid), 0);
        if_pc = 32'h8000_0104;
        tick();
        imem_ready = 1'b1; imem_error = 1'b1; imem_data = 32'h1234_5678;
        settle();
        check("t5_err_valid", 32'(if_inst_valid), 1);
        check("t5_err_flag", 32'(if_bus_error), 1);
        check("t5_err_instr", if_instruction, NOP);
        tick();
        imem_ready = 1'b0; imem_error = 1'b0;

        // T6: reset mid-request, then flush+ready collision
        if_pc = 32'h8000_0200;
        tick();
        check("t6_launch_addr", imem_address, 32'h8000_0200);
        tick();
        rst = 1'b1; imem_ready = 1'b1; imem_data = 32'hCAFE_F00D;
        settle();
        check("t6_rst_valid", 32'(if_inst_valid), 0);
        check("t6_rst_stall", 32'(if_fetch_stall), 1);
        tick();
        check("t6_rst_req", 32'(imem_valid), 0);
        rst = 1'b0; imem_ready = 1'b0;
        tick();
        check("t6_relaunch", 32'(imem_valid), 1);
        if_flush = 1'b1; imem_ready = 1'b1; imem_data = 32'h5555_AAAA;
        settle();
        check("t6_collide_valid", 32'(if_inst_valid), 0);
        check("t6_collide_stall", 32'(if_fetch_stall), 1);
        tick();
        if_flush = 1'b0; imem_ready = 1'b0;
        check("t6_after_req", 32'(imem_valid), 0);
        check("t6_after_valid", 32'(if_inst_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
